seq_pattern_detector: RTL and testbench

- Parametrised serial bit-pattern detector. Samples one bit per qualified cycle and pulses pattern_found when the most recent cfg_len bits equal a run-time programmable pattern.
- Adds run-time pattern and length load, overlap/non-overlap mode, input qualification and a saturating hit counter.
- Sits between a serial front end and the control logic that consumes match events.

---
 rtl/seq_pattern_detector_pkg.sv | 40 ++++
 rtl/seq_pattern_detector_shift_hist.sv | 62 ++++++
 rtl/seq_pattern_detector.sv | 171 +++++++++++++++++
 tb/tb_seq_pattern_detector.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_detector_pkg.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector_pkg
// Shared widths, reset defaults and the configuration record for the serial
// pattern detector.
//
// The configuration struct is sized for the largest supported pattern
// (PAT_MAX bits). A detector built with a smaller PAT_W uses only the low bits
// of each field. The unused upper bits are tied to zero.
//
// Optional feature macro: PATTERN_DETECTOR_MASK_EN adds a don't-care mask
// field to the configuration record.
// -----------------------------------------------------------------------------
package seq_pattern_detector_pkg;

    localparam int PAT_MAX   = 32;   // largest PAT_W the config record holds
    localparam int LEN_MAX_W = 6;    // $clog2(PAT_MAX+1)

    localparam logic [7:0] DEF_RST_PAT = 8'b0001_1010;
    localparam int         DEF_RST_LEN = 5;

    // Width of a length value able to hold 0..pat_w.
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Width of the fill counter, which also counts 0..pat_w.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    typedef struct packed {
        logic [PAT_MAX-1:0]   pattern;
        logic [LEN_MAX_W-1:0] len;
        logic                 overlap;
`ifdef PATTERN_DETECTOR_MASK_EN
        logic [PAT_MAX-1:0]   mask;
`endif
    } pd_cfg_t;

endpackage

// File: rtl/seq_pattern_detector_shift_hist.sv
// -----------------------------------------------------------------------------
// pd_shift_hist
// Serial history register and fill counter for the pattern detector.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   sample_i in   accept bit_i this cycle
//   bit_i    in   incoming serial bit
//   clear_i  in   empty the history and fill counter (wins over sample_i)
//   cand_o   out  {history, bit_i}: the window the compare looks at
//   fill_o   out  number of valid history bits, saturating at PAT_W
// -----------------------------------------------------------------------------
module pd_shift_hist
    import seq_pattern_detector_pkg::*;
#(
    parameter int PAT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_i,
    input  logic                         bit_i,
    input  logic                         clear_i,
    output logic [PAT_W-1:0]             cand_o,
    output logic [fill_width(PAT_W)-1:0] fill_o
);

    localparam int FILL_W = fill_width(PAT_W);

    // Only PAT_W-1 bits of history are kept: the oldest bit of the candidate
    // would shift out on the next sample and is never compared again.
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    assign cand_o = {hist_q, bit_i};
    assign fill_o = fill_q;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (sample_i) begin
            hist_d = cand_o[PAT_W-2:0];
            if (fill_q != FILL_W'(PAT_W)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
// Serial bit-pattern detector. One bit is sampled per cycle with stream_valid
// high. pattern_found pulses one cycle after the edge that samples the last
// bit of a match against the programmed pattern (bit 0 = newest bit).
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   stream_in     in   serial data bit
//   stream_valid  in   qualifies stream_in
//   cfg_load      in   strobe: latch cfg_pattern/cfg_len/cfg_overlap
//                      (and cfg_mask), clear history; same-cycle bit dropped
//   cfg_pattern   in   pattern, bit 0 is the last-received bit
//   cfg_len       in   active length; 0 or > PAT_W is clamped to PAT_W
//   cfg_overlap   in   1 = overlapping matches allowed
//   cfg_mask      in   (PATTERN_DETECTOR_MASK_EN only) 1 = don't-care position
//   clear_count   in   synchronous clear of hit_count, beats a same-cycle hit
//   pattern_found out  registered one-cycle match pulse
//   hit_count     out  saturating match counter
//   busy_fill     out  number of valid history bits (debug)
//
// Optional feature macro: PATTERN_DETECTOR_MASK_EN
// -----------------------------------------------------------------------------
module seq_pattern_detector
    import seq_pattern_detector_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 16,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
    parameter int               RST_LEN = DEF_RST_LEN,
    parameter logic             RST_OVL = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stream_in,
    input  logic                        stream_valid,
    input  logic                        cfg_load,
    input  logic [PAT_W-1:0]            cfg_pattern,
    input  logic [len_width(PAT_W)-1:0] cfg_len,
    input  logic                        cfg_overlap,
`ifdef PATTERN_DETECTOR_MASK_EN
    input  logic [PAT_W-1:0]            cfg_mask,
`endif
    input  logic                        clear_count,
    output logic                        pattern_found,
    output logic [CNT_W-1:0]            hit_count,
    output logic [len_width(PAT_W)-1:0] busy_fill
);

    localparam int LEN_W  = len_width(PAT_W);
    localparam int FILL_W = fill_width(PAT_W);

    function automatic pd_cfg_t reset_cfg();
        pd_cfg_t c;
        c         = '0;
        c.pattern = PAT_MAX'(RST_PAT);
        c.len     = LEN_MAX_W'(RST_LEN);
        c.overlap = RST_OVL;
        return c;
    endfunction

    localparam pd_cfg_t RST_CFG = reset_cfg();

    pd_cfg_t           cfg_q, cfg_d;
    logic              found_q, found_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PAT_W-1:0]  cand;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pat;
    logic [LEN_W-1:0]  len;
    logic [PAT_W-1:0]  len_mask;
    logic [PAT_W-1:0]  care_mask;
    logic [LEN_W:0]    fill_p1;
    logic              sample;
    logic              match;
    logic              hit;
    logic              hist_clear;
    logic              cfg_unused;

    // ---------------------------------------------------------------- config
    always_comb begin
        cfg_d = cfg_q;
        if (cfg_load) begin
            cfg_d         = '0;
            cfg_d.pattern = PAT_MAX'(cfg_pattern);
            cfg_d.len     = ((cfg_len == '0) || (cfg_len > LEN_W'(PAT_W)))
                            ? LEN_MAX_W'(PAT_W) : LEN_MAX_W'(cfg_len);
            cfg_d.overlap = cfg_overlap;
`ifdef PATTERN_DETECTOR_MASK_EN
            cfg_d.mask    = PAT_MAX'(cfg_mask);
`endif
        end
    end

    assign pat = cfg_q.pattern[PAT_W-1:0];
    assign len = cfg_q.len[LEN_W-1:0];

    // Upper bits of the record are constant zero for PAT_W < PAT_MAX.
    assign cfg_unused = ^cfg_q;

    // --------------------------------------------------------------- history
    // A load cycle never samples: the bit presented with cfg_load is dropped.
    assign sample = stream_valid & ~cfg_load;

    // Non-overlap mode restarts from an empty history after every match.
    assign hist_clear = cfg_load | (hit & ~cfg_q.overlap);

    pd_shift_hist #(
        .PAT_W (PAT_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .sample_i (sample),
        .bit_i    (stream_in),
        .clear_i  (hist_clear),
        .cand_o   (cand),
        .fill_o   (fill)
    );

    // --------------------------------------------------------------- compare
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(len)) begin
                len_mask[i] = 1'b1;
            end
        end
    end

`ifdef PATTERN_DETECTOR_MASK_EN
    assign care_mask = len_mask & ~cfg_q.mask[PAT_W-1:0];
`else
    assign care_mask = len_mask;
`endif

    // The candidate holds fill history bits plus the incoming one.
    assign fill_p1 = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    assign match   = (fill_p1 >= {1'b0, len}) && (((cand ^ pat) & care_mask) == '0);
    assign hit     = sample & match;

    // ----------------------------------------------------------- pulse/count
    assign found_d = hit;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_count) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q   <= RST_CFG;
            found_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cfg_q   <= cfg_d;
            found_q <= found_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pattern_found = found_q;
    assign hit_count     = cnt_q;
    assign busy_fill     = fill;

endmodule

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       stream_in;
    logic       stream_valid;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
`ifdef PATTERN_DETECTOR_MASK_EN
    logic [7:0] cfg_mask;
`endif
    logic       clear_count;

    logic        pf_a, pf_b;
    logic [15:0] hit_a;
    logic [1:0]  hit_b;
    logic [3:0]  fill_a, fill_b;

    int errors  = 0;
    int checks  = 0;
    int exp_hit = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    seq_pattern_detector dut (
        .clk           (clk),
        .rst           (rst),
        .stream_in     (stream_in),
        .stream_valid  (stream_valid),
        .cfg_load      (cfg_load),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_overlap   (cfg_overlap),
`ifdef PATTERN_DETECTOR_MASK_EN
        .cfg_mask      (cfg_mask),
`endif
        .clear_count   (clear_count),
        .pattern_found (pf_a),
        .hit_count     (hit_a),
        .busy_fill     (fill_a)
    );

    seq_pattern_detector #(.CNT_W(2)) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .stream_in     (stream_in),
        .stream_valid  (stream_valid),
        .cfg_load      (cfg_load),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_overlap   (cfg_overlap),
`ifdef PATTERN_DETECTOR_MASK_EN
        .cfg_mask      (cfg_mask),
`endif
        .clear_count   (clear_count),
        .pattern_found (pf_b),
        .hit_count     (hit_b),
        .busy_fill     (fill_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_hits(input string tag);
        chk({tag, "_hits"}, 32'(hit_a), 32'(exp_hit));
        chk({tag, "_hits_sat"}, 32'(hit_b), (exp_hit > 3) ? 32'd3 : 32'(exp_hit));
    endtask

    // Drive one cycle; the expected pulse is queued with the stimulus and
    // popped once the edge that produces it has passed.
    task automatic step(input logic b, input logic v, input logic e, input string tag);
        logic e_pop;
        stream_in    = b;
        stream_valid = v;
        exp_q.push_back(e);
        if (clear_count) exp_hit = 0;
        else if (e)      exp_hit++;
        @(posedge clk);
        #1;
        e_pop = exp_q.pop_front();
        chk({tag, "_pf"}, 32'(pf_a), 32'(e_pop));
        chk({tag, "_pf_sat"}, 32'(pf_b), 32'(e_pop));
        stream_valid = 1'b0;
        cfg_load     = 1'b0;
        clear_count  = 1'b0;
    endtask

    // Bits and expected pulses given oldest first in the MSBs.
    task automatic send(input logic [15:0] bits, input logic [15:0] exp, input int n,
                        input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, exp[i], tag);
        end
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov,
                        input logic [7:0] m, input string tag);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
`ifdef PATTERN_DETECTOR_MASK_EN
        cfg_mask    = m;
`else
        if (m != 8'h00) $display("note: mask ignored in this build");
`endif
        cfg_load = 1'b1;
        step(1'b1, 1'b1, 1'b0, tag);
        chk({tag, "_fill"}, 32'(fill_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        stream_in    = 1'b0;
        stream_valid = 1'b0;
        cfg_load     = 1'b0;
        cfg_pattern  = 8'h00;
        cfg_len      = 4'd0;
        cfg_overlap  = 1'b0;
`ifdef PATTERN_DETECTOR_MASK_EN
        cfg_mask     = 8'h00;
`endif
        clear_count  = 1'b0;
        #2;
        chk("reset_pf", 32'(pf_a), 32'd0);
        chk("reset_hits", 32'(hit_a), 32'd0);
        chk("reset_fill", 32'(fill_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset configuration 11010, overlapping.
        send(16'b11010_11010, 16'b00001_00001, 10, "rstcfg");
        chk_hits("rstcfg");
        chk("rstcfg_fill_sat", 32'(fill_a), 32'd8);

        clear_count = 1'b1;
        step(1'b0, 1'b0, 1'b0, "clear");
        chk_hits("clear");

        // Pattern 11: overlap gives 3 hits on 1111, non-overlap gives 2.
        load(8'h03, 4'd2, 1'b1, 8'h00, "ld11o");
        send(16'b1111, 16'b0111, 4, "ovl");
        chk_hits("ovl");
        load(8'h03, 4'd2, 1'b0, 8'h00, "ld11n");
        send(16'b1111, 16'b0101, 4, "novl");
        chk_hits("novl");

        // clear_count beats a simultaneous match; the pulse still appears.
        step(1'b1, 1'b1, 1'b0, "clrhit_a");
        clear_count = 1'b1;
        step(1'b1, 1'b1, 1'b1, "clrhit_b");
        chk_hits("clrhit");

        // Valid toggling: hold cycles carry garbage and never pulse.
        load(8'h1A, 4'd5, 1'b1, 8'h00, "ldtog");
        step(1'b1, 1'b1, 1'b0, "tog1");
        step(1'b0, 1'b0, 1'b0, "tog1h");
        step(1'b1, 1'b1, 1'b0, "tog2");
        step(1'b1, 1'b0, 1'b0, "tog2h");
        step(1'b0, 1'b1, 1'b0, "tog3");
        step(1'b1, 1'b0, 1'b0, "tog3h");
        step(1'b1, 1'b1, 1'b0, "tog4");
        step(1'b0, 1'b0, 1'b0, "tog4h");
        step(1'b0, 1'b1, 1'b1, "tog5");
        step(1'b1, 1'b0, 1'b0, "tog5h");
        chk_hits("tog");

        // Load mid-pattern discards history.
        send(16'b110, 16'b000, 3, "mid_pre");
        load(8'h1A, 4'd5, 1'b1, 8'h00, "ldmid");
        send(16'b10, 16'b00, 2, "mid_post");
        send(16'b11010, 16'b00001, 5, "mid_full");
        chk_hits("mid");

        // Illegal lengths clamp to the full 8 bits.
        load(8'hFF, 4'd0, 1'b1, 8'h00, "ldlen0");
        send(16'h01FF, 16'b000000011, 9, "len0");
        chk("len0_fill", 32'(fill_a), 32'd8);
        load(8'hFF, 4'd12, 1'b0, 8'h00, "ldlen12");
        send(16'h00FF, 16'b00000001, 8, "len12");
        chk_hits("clamp");

`ifdef PATTERN_DETECTOR_MASK_EN
        // Pattern 101 with the middle bit don't-care.
        load(8'h05, 4'd3, 1'b0, 8'h02, "ldmask");
        send(16'b101_111_100, 16'b001_001_000, 9, "mask");
        chk_hits("mask");
`endif

        // Asynchronous reset while a pulse is being shown.
        load(8'h03, 4'd2, 1'b1, 8'h00, "ldrst");
        send(16'b11, 16'b01, 2, "prerst");
        #2;
        rst = 1'b1;
        #1;
        exp_hit = 0;
        chk("midrst_pf", 32'(pf_a), 32'd0);
        chk("midrst_pf_sat", 32'(pf_b), 32'd0);
        chk("midrst_fill", 32'(fill_a), 32'd0);
        chk_hits("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset restores the 11010 configuration.
        send(16'b1111010, 16'b0000001, 7, "postrst");
        chk_hits("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
